// File: rtl/div_unit.sv
// Iterative restoring radix-2 divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per clock; divide-by-zero and signed overflow finish without iterating.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result,
    output logic            o_div_zero
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state, state_next;
    logic            rem_sel_q;
    logic [XLEN-1:0] divisor_q;
    logic [XLEN-1:0] quot_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] result_q;
    logic [CW-1:0]   cnt_q;
    logic            sign_q;
    logic            sign_r;
    logic            div_zero_q;

    logic            start_ok;
    logic            is_signed;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            b_zero, overflow;
    logic [XLEN:0]   rem_sh, trial;
    logic [XLEN-1:0] quot_fix, rem_fix, done_value;

    assign start_ok  = i_start && (state != CALC);
    assign is_signed = ~i_op[0];
    assign a_neg     = is_signed & i_a[XLEN-1];
    assign b_neg     = is_signed & i_b[XLEN-1];
    // Unsigned magnitudes: |MIN_NEG| comes out as 2^(XLEN-1), which is exactly what the datapath needs.
    assign a_mag     = a_neg ? -i_a : i_a;
    assign b_mag     = b_neg ? -i_b : i_b;
    assign b_zero    = (i_b == '0);
    assign overflow  = is_signed && (i_a == MIN_NEG) && (i_b == '1);

    // Trial subtraction is one bit wider than XLEN so the shifted-out remainder MSB is never lost.
    assign rem_sh = {rem_q, quot_q[XLEN-1]};
    assign trial  = rem_sh - {1'b0, divisor_q};

    assign quot_fix   = sign_q ? -quot_q : quot_q;
    assign rem_fix    = sign_r ? -rem_q  : rem_q;
    assign done_value = rem_sel_q ? rem_fix : quot_fix;

    always_comb begin
        // NOTE: default assigned first so every path drives state_next and no latch is inferred.
        state_next = state;
        case (state)
            IDLE: begin
                if (i_start) state_next = (b_zero || overflow) ? DONE : CALC;
            end
            CALC: begin
                if (cnt_q == '0) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
                if (i_start) state_next = (b_zero || overflow) ? DONE : CALC;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: reset clears the datapath as well as the FSM, so an aborted operation leaves no stale result.
        if (i_rst) begin
            state      <= IDLE;
            rem_sel_q  <= 1'b0;
            divisor_q  <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            result_q   <= '0;
            cnt_q      <= '0;
            sign_q     <= 1'b0;
            sign_r     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state == DONE) result_q <= done_value;
            if (start_ok) begin
                rem_sel_q  <= i_op[1];
                div_zero_q <= b_zero;
                cnt_q      <= CW'(XLEN - 1);
                if (b_zero) begin
                    quot_q    <= '1;
                    rem_q     <= i_a;
                    divisor_q <= i_b;
                    sign_q    <= 1'b0;
                    sign_r    <= 1'b0;
                end else if (overflow) begin
                    quot_q    <= MIN_NEG;
                    rem_q     <= '0;
                    divisor_q <= b_mag;
                    sign_q    <= 1'b0;
                    sign_r    <= 1'b0;
                end else begin
                    quot_q    <= a_mag;
                    rem_q     <= '0;
                    divisor_q <= b_mag;
                    sign_q    <= a_neg ^ b_neg;
                    sign_r    <= a_neg;
                end
            end else if (state == CALC) begin
                rem_q  <= trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
                quot_q <= {quot_q[XLEN-2:0], ~trial[XLEN]};
                cnt_q  <= cnt_q - CW'(1);
            end
        end
    end

    assign o_busy     = (state == CALC);
    assign o_done     = (state == DONE);
    assign o_result   = (state == DONE) ? done_value : result_q;
    assign o_div_zero = div_zero_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: scoreboard of expected results, checked by a monitor on each o_done.
module tb_div_unit;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [1:0]  i_op = 2'b00;
    logic [31:0] i_a = '0;
    logic [31:0] i_b = '0;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_result;
    logic        o_div_zero;

    div_unit #(.XLEN(32)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_op       (i_op),
        .i_a        (i_a),
        .i_b        (i_b),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_result   (o_result),
        .o_div_zero (o_div_zero)
    );

    always #5 i_clk = ~i_clk;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic        dz;
        int          lat;
        int          start_cyc;
    } exp_t;

    typedef struct packed {
        logic [31:0] res;
        logic        dz;
        logic        special;
    } model_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   busy_cnt = 0;
    int   done_count = 0;
    int   last_done_cyc = 0;
    int   prev_done_cyc = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Reference model written from the RV32M definition, using the simulator's own signed arithmetic.
    function automatic model_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        model_t m;
        int sa, sb;
        m = '0;
        sa = a;
        sb = b;
        if (b == 32'h0) begin
            m.dz = 1'b1;
            m.special = 1'b1;
            m.res = op[1] ? a : 32'hFFFF_FFFF;
        end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            m.special = 1'b1;
            m.res = op[1] ? 32'h0 : 32'h8000_0000;
        end else if (!op[0]) begin
            m.res = op[1] ? 32'(sa % sb) : 32'(sa / sb);
        end else begin
            m.res = op[1] ? (a % b) : (a / b);
        end
        return m;
    endfunction

    // Monitor: pops the scoreboard on every o_done and checks result, flag, latency and busy length.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                busy_cnt = 0;
            end else begin
                if (o_busy) busy_cnt++;
                if (o_done) begin
                    done_count++;
                    prev_done_cyc = last_done_cyc;
                    last_done_cyc = cyc;
                    if (sb_q.size() == 0) begin
                        check("spurious_done", {31'b0, o_done}, 32'h0);
                    end else begin
                        e = sb_q.pop_front();
                        check({e.tag, ".result"}, o_result, e.res);
                        check({e.tag, ".div_zero"}, {31'b0, o_div_zero}, {31'b0, e.dz});
                        check({e.tag, ".latency"}, cyc + 1 - e.start_cyc, e.lat);
                        check({e.tag, ".busy_cycles"}, busy_cnt, (e.lat == 1) ? 0 : 32);
                        check({e.tag, ".busy_with_done"}, {31'b0, o_busy}, 32'h0);
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    // Called at a negedge: drives one start pulse and records what the monitor must see.
    task automatic issue(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input logic dz, input int lat);
        exp_t e;
        e.tag = tag;
        e.res = res;
        e.dz = dz;
        e.lat = lat;
        e.start_cyc = cyc + 1;
        i_op = op;
        i_a = a;
        i_b = b;
        i_start = 1'b1;
        sb_q.push_back(e);
        @(negedge i_clk);
        i_start = 1'b0;
        i_a = $urandom;
        i_b = $urandom;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge i_clk);
        if (sb_q.size() != 0) begin
            check("timeout_pending_ops", sb_q.size(), 0);
            sb_q.delete();
        end
        @(negedge i_clk);
    endtask

    task automatic run_case(input string tag, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] res, input logic dz, input int lat);
        @(negedge i_clk);
        issue(tag, op, a, b, res, dz, lat);
        wait_empty();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_t m;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        int          done_before;
        bit          seen;

        repeat (2) @(negedge i_clk);
        check("reset.busy", {31'b0, o_busy}, 32'h0);
        check("reset.done", {31'b0, o_done}, 32'h0);
        check("reset.result", o_result, 32'h0);
        check("reset.div_zero", {31'b0, o_div_zero}, 32'h0);
        i_rst = 1'b0;

        run_case("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 33);
        run_case("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 1'b0, 33);
        run_case("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33);
        run_case("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33);
        run_case("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 33);
        run_case("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1);
        run_case("rem_5_0", OP_REM, 32'd5, 32'd0, 32'd5, 1'b1, 1);
        run_case("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
        run_case("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 1);
        run_case("div_min_1", OP_DIV, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, 33);
        run_case("rem_min_3", OP_REM, 32'h8000_0000, 32'd3, 32'hFFFF_FFFE, 1'b0, 33);
        run_case("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 33);
        run_case("remu_max_max", OP_REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 33);
        run_case("div_m1_0", OP_DIV, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 1'b1, 1);

        for (int i = 0; i < 10; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            m = model(rop, ra, rb);
            run_case($sformatf("rand%0d", i), rop, ra, rb, m.res, m.dz, m.special ? 1 : 33);
        end

        // Start pulse during CALC must be ignored: exactly one done, with the original operands.
        @(negedge i_clk);
        issue("calc_start_ignored", OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 33);
        repeat (3) @(negedge i_clk);
        i_op = OP_DIVU;
        i_a = 32'd1;
        i_b = 32'd1;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        wait_empty();
        done_before = done_count;
        repeat (40) @(negedge i_clk);
        check("calc_start.extra_done", done_count - done_before, 0);

        // Back-to-back: second start issued in the DONE cycle of the first.
        @(negedge i_clk);
        issue("b2b_divu_20_4", OP_DIVU, 32'd20, 32'd4, 32'd5, 1'b0, 33);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (o_done) seen = 1'b1;
            else @(negedge i_clk);
        end
        check("b2b.first_done_seen", {31'b0, seen}, 32'h1);
        issue("b2b_remu_10_3", OP_REMU, 32'd10, 32'd3, 32'd1, 1'b0, 33);
        wait_empty();
        check("b2b.done_gap", last_done_cyc - prev_done_cyc, 33);

        // Abort: reset in CALC cycle 10 after an ignored start in CALC cycle 5.
        @(negedge i_clk);
        i_op = OP_DIVU;
        i_a = 32'hFFFF_FFFF;
        i_b = 32'd1;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (4) @(negedge i_clk);
        i_op = OP_DIVU;
        i_a = 32'd6;
        i_b = 32'd2;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (4) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        check("abort.busy", {31'b0, o_busy}, 32'h0);
        check("abort.done", {31'b0, o_done}, 32'h0);
        check("abort.result", o_result, 32'h0);
        done_before = done_count;
        repeat (45) @(negedge i_clk);
        check("abort.no_done", done_count - done_before, 0);
        run_case("after_abort_divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 1'b0, 33);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
